// File: rtl/aes_pkg.sv
// AES-128 inverse-cipher types, constants and GF(2^8) / round-step helper functions.
// Latency: none; pure functions and types, no state.
// Backpressure: not applicable; nothing here has a handshake.
//
// Contents: aes_state_t, NR, fsm_t, xtime, gf_mul, inv_sbox, inv_shift_rows, inv_mix_columns.
// State layout is column-major: byte k = row (k mod 4), column (k div 4), at bits [127-8k -: 8].
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    localparam int NR = 10;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    // Inverse S-box, entry 0 in the top byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_sbox(logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    // Output byte (r,c) takes input byte (r, (c-r) mod 4): row r rotates right by r.
    function automatic aes_state_t inv_shift_rows(aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(aes_state_t s);
        aes_state_t o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Bundles the ciphertext-in / plaintext-out handshakes and the round-key lookup of the inverse cipher.
// Latency: none; wires only.
// Backpressure: valid/ready on both sides; rk returns combinationally for rk_idx.
//
// master: drives in_valid, ciphertext, rk, out_ready (upstream, key store, downstream).
// slave : drives in_ready, rk_idx, out_valid, plaintext (the cipher).
interface aes_inv_cipher_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t ciphertext;
    logic [3:0] rk_idx;
    aes_state_t rk;
    logic       out_valid;
    logic       out_ready;
    aes_state_t plaintext;

    modport master (
        output in_valid, ciphertext, rk, out_ready,
        input  in_ready, rk_idx, out_valid, plaintext
    );

    modport slave (
        input  in_valid, ciphertext, rk, out_ready,
        output in_ready, rk_idx, out_valid, plaintext
    );
endinterface

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Latency: combinational.
// Backpressure: none; the caller decides when to register next_state.
//
// Ports: state (current block), rk (round key), last (skip InvMixColumns), next_state (result).
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t rk,
    input  logic       last,
    output aes_state_t next_state
);
    aes_state_t shifted;
    aes_state_t subbed;
    aes_state_t keyed;

    assign shifted = inv_shift_rows(state);

    always_comb begin
        subbed = '0;
        for (int k = 0; k < 16; k++) begin
            subbed[127 - 8*k -: 8] = inv_sbox(shifted[127 - 8*k -: 8]);
        end
    end

    assign keyed      = subbed ^ rk;
    assign next_state = last ? keyed : inv_mix_columns(keyed);
endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one inverse round per clock, round keys fetched by rk_idx.
// Latency: 11 cycles from accept to out_valid; next accept no earlier than 12 cycles after the last.
// Backpressure: plaintext/out_valid hold while out_ready=0; in_ready only in IDLE, never while busy.
//
// Ports: clk, rst (async, active-high); bus (slave): in_valid/in_ready/ciphertext accept,
// rk_idx/rk key-store lookup (same-cycle), out_valid/out_ready/plaintext result.
module aes_inv_cipher
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    aes_inv_cipher_if.slave  bus
);
    fsm_t       fsm;
    logic [3:0] round;
    aes_state_t state;
    logic       in_rdy;
    logic       out_vld;
    logic [3:0] key_idx;
    aes_state_t round_out;

    aes_inv_round u_round (
        .state      (state),
        .rk         (bus.rk),
        .last       (fsm == FINAL),
        .next_state (round_out)
    );

    // key_idx is registered alongside the state transition so it always names the key
    // the current state consumes; the key store answers within the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            round   <= 4'd0;
            state   <= '0;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
            key_idx <= 4'(NR);
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        state   <= bus.ciphertext ^ bus.rk;
                        round   <= 4'(NR - 1);
                        key_idx <= 4'(NR - 1);
                        in_rdy  <= 1'b0;
                        fsm     <= ROUND;
                    end
                end
                ROUND: begin
                    state   <= round_out;
                    // Leaving round 1 decrements to 0, which is also the FINAL key index.
                    round   <= round - 4'd1;
                    key_idx <= round - 4'd1;
                    if (round == 4'd1) fsm <= FINAL;
                end
                FINAL: begin
                    state   <= round_out;
                    out_vld <= 1'b1;
                    key_idx <= 4'(NR);
                    fsm     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        fsm     <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.rk_idx    = key_idx;
    assign bus.plaintext = state;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: FIPS-197 vectors, latency, key sequencing, corner cases.
// Latency: expects out_valid 11 cycles after accept, 12-cycle back-to-back issue.
// Backpressure: exercises out_ready=0 holds, busy in_valid pulses and mid-operation reset.
module tb_aes_inv_cipher;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_inv_cipher_if bus();

    aes_inv_cipher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Key store: combinational lookup from the bench's own expanded schedule.
    logic [127:0] rk_tab [0:15];
    assign bus.rk = rk_tab[bus.rk_idx];

    logic [7:0] sb [0:255];
    int total = 0;
    int bad   = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           hold;
        int           pulse;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] v, int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // Forward S-box from first principles: GF inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (i != 0 && gm(8'(i), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb[i] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) rk_tab[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // Issue one block, follow it to out_valid, optionally backpressure and/or pulse in_valid while busy.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                             input int hold, input int pulse, input string tag);
        int  k;
        bit  got;
        bit  seq_ok;
        bit  stable;
        bit  extra;
        @(negedge clk);
        bus.out_ready = (hold == 0);
        chk({tag, "_in_ready_idle"}, 128'(bus.in_ready), 128'd1);
        chk({tag, "_rk_idx_idle"}, 128'(bus.rk_idx), 128'd10);
        bus.in_valid   = 1'b1;
        bus.ciphertext = ct;
        got    = 1'b0;
        seq_ok = 1'b1;
        k      = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            bus.in_valid   = 1'b0;
            bus.ciphertext = ~ct;
            if (pulse > 0 && (k == pulse || k == pulse + 1)) bus.in_valid = 1'b1;
            if (bus.out_valid === 1'b1) got = 1'b1;
            else if (bus.rk_idx !== 4'(10 - k) || bus.in_ready !== 1'b0) seq_ok = 1'b0;
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout out_valid never rose within %0d cycles", tag, k);
        end
        chk({tag, "_latency"}, 128'(k), 128'd11);
        chk({tag, "_rk_seq"}, 128'(seq_ok), 128'd1);
        chk({tag, "_plaintext"}, bus.plaintext, pt);
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.plaintext !== pt) stable = 1'b0;
            end
            chk({tag, "_hold_stable"}, 128'(stable), 128'd1);
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_in_ready_after"}, 128'(bus.in_ready), 128'd1);
        chk({tag, "_out_valid_after"}, 128'(bus.out_valid), 128'd0);
        if (pulse > 0) begin
            extra = 1'b0;
            repeat (14) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) extra = 1'b1;
            end
            chk({tag, "_no_second_accept"}, 128'(extra), 128'd0);
        end
    endtask

    initial begin
        int           waited;
        bit           seen;
        int           accepts;
        int           outs;
        int           acc_cyc [2];
        logic [127:0] res [2];

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.ciphertext = '0;
        for (int i = 0; i < 16; i++) rk_tab[i] = '0;
        build_sbox();

        vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT, hold: 0,  pulse: 0};
        vecs[1] = '{key: B_KEY,  ct: B_CT,  pt: B_PT,  hold: 0,  pulse: 0};
        vecs[2] = '{key: B_KEY,  ct: B_CT,  pt: B_PT,  hold: 20, pulse: 0};
        vecs[3] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT, hold: 0,  pulse: 3};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_rk_idx", 128'(bus.rk_idx), 128'd10);
        chk("rst_plaintext", bus.plaintext, 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            expand_key(vecs[i].key);
            run_block(vecs[i].ct, vecs[i].pt, vecs[i].hold, vecs[i].pulse, $sformatf("vec%0d", i));
        end

        // Reset in the middle of round 5.
        expand_key(C1_KEY);
        @(negedge clk);
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.ciphertext = C1_CT;
        @(negedge clk);
        bus.in_valid = 1'b0;
        waited = 0;
        while (bus.rk_idx !== 4'd5 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("mid_rst_reached_round5", 128'(bus.rk_idx), 128'd5);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("mid_rst_rk_idx", 128'(bus.rk_idx), 128'd10);
        chk("mid_rst_plaintext", bus.plaintext, 128'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk("mid_rst_no_output", 128'(seen), 128'd0);
        run_block(C1_CT, C1_PT, 0, 0, "post_rst");

        // Back-to-back C.1 then B with out_ready tied high and in_valid held.
        expand_key(C1_KEY);
        @(negedge clk);
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.ciphertext = C1_CT;
        accepts = 0;
        outs    = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        res[0] = '0;
        res[1] = '0;
        for (int c = 0; c < 60 && outs < 2; c++) begin
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && accepts < 2) begin
                acc_cyc[accepts] = c;
                accepts++;
            end
            if (bus.out_valid === 1'b1) begin
                res[outs] = bus.plaintext;
                outs++;
                if (outs == 1) expand_key(B_KEY);
            end
            @(negedge clk);
            if (accepts == 1) bus.ciphertext = B_CT;
            if (accepts == 2) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("b2b_outputs", 128'(outs), 128'd2);
        chk("b2b_first_pt", res[0], C1_PT);
        chk("b2b_second_pt", res[1], B_PT);
        chk("b2b_issue_interval", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
